// File: rtl/move_ctrl_pkg.sv
// Shared definitions for the movement sequencer: direction codes, FSM state encodings,
// default parameters and commit helpers. ST_COOL exists only with MOVE_CTRL_COOLDOWN_EN.
package move_ctrl_pkg;

  localparam int MAP_W_DEF           = 16;
  localparam int MAP_H_DEF           = 16;
  localparam int INIT_X_DEF          = 1;
  localparam int INIT_Y_DEF          = 1;
  localparam int INIT_HEALTH_DEF     = 10;
  localparam int HEALTH_MAX_DEF      = 200;
  localparam int COOLDOWN_CYCLES_DEF = 1000000;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_COMMIT  = 3'd3
`ifdef MOVE_CTRL_COOLDOWN_EN
    , ST_COOL  = 3'd4
`endif
  } state_e;

  function automatic logic [7:0] sat_health(input logic [7:0] h, input logic [7:0] hmax);
    return (h > hmax) ? hmax : h;
  endfunction

  // A full key ring that the resolver wrapped back to zero stays full.
  function automatic logic [3:0] hold_keys(input logic [3:0] old_k, input logic [3:0] new_k);
    return ((old_k == 4'd15) && (new_k == 4'd0)) ? 4'd15 : new_k;
  endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Bundle of the command, map RAM, resolver and player-state signals around move_ctrl.
// master = the controller side, slave = the surrounding environment.
interface move_ctrl_if;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        move_ready;

  logic [7:0]  map_rd_addr;
  logic [15:0] map_rd_data;
  logic        map_wr_en;
  logic [7:0]  map_wr_addr;
  logic [15:0] map_wr_data;

  logic [15:0] res_tile_id;
  logic [3:0]  res_pos_x;
  logic [3:0]  res_pos_y;
  logic [3:0]  res_player_x;
  logic [3:0]  res_player_y;
  logic [3:0]  res_key_num;
  logic [7:0]  res_health;

  logic [3:0]  res_goto_x;
  logic [3:0]  res_goto_y;
  logic [3:0]  res_key_num_in;
  logic [7:0]  res_health_in;
  logic [15:0] res_new_tile_id;

  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic [3:0]  key_num;
  logic [7:0]  health;
  logic        move_done;
  logic        move_blocked;

  modport master (
    input  move_valid, move_dir, map_rd_data,
           res_goto_x, res_goto_y, res_key_num_in, res_health_in, res_new_tile_id,
    output move_ready, map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
           res_tile_id, res_pos_x, res_pos_y, res_player_x, res_player_y,
           res_key_num, res_health,
           player_x, player_y, key_num, health, move_done, move_blocked
  );

  modport slave (
    output move_valid, move_dir, map_rd_data,
           res_goto_x, res_goto_y, res_key_num_in, res_health_in, res_new_tile_id,
    input  move_ready, map_rd_addr, map_wr_en, map_wr_addr, map_wr_data,
           res_tile_id, res_pos_x, res_pos_y, res_player_x, res_player_y,
           res_key_num, res_health,
           player_x, player_y, key_num, health, move_done, move_blocked
  );
endinterface

// File: rtl/move_target.sv
// Combinational step target: position + direction -> neighbouring tile and off-map flag.
// An off-map step reports the unchanged position as its target.
module move_target
  import move_ctrl_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEF,
  parameter int MAP_H = MAP_H_DEF
) (
  input  logic [3:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic [1:0] i_dir,
  output logic [3:0] o_tgt_x,
  output logic [3:0] o_tgt_y,
  output logic       o_off_map
);

  localparam logic [3:0] X_MAX = 4'(MAP_W - 1);
  localparam logic [3:0] Y_MAX = 4'(MAP_H - 1);

  always_comb begin
    o_tgt_x   = i_pos_x;
    o_tgt_y   = i_pos_y;
    o_off_map = 1'b0;
    case (i_dir)
      DIR_UP: begin
        if (i_pos_y == 4'd0) o_off_map = 1'b1;
        else                 o_tgt_y   = i_pos_y - 4'd1;
      end
      DIR_DOWN: begin
        if (i_pos_y == Y_MAX) o_off_map = 1'b1;
        else                  o_tgt_y   = i_pos_y + 4'd1;
      end
      DIR_LEFT: begin
        if (i_pos_x == 4'd0) o_off_map = 1'b1;
        else                 o_tgt_x   = i_pos_x - 4'd1;
      end
      default: begin
        if (i_pos_x == X_MAX) o_off_map = 1'b1;
        else                  o_tgt_x   = i_pos_x + 4'd1;
      end
    endcase
  end

endmodule

// File: rtl/move_ctrl.sv
// Player movement sequencer: accept one step, read the target tile, drive the resolver,
// commit player state and tile write-back. Optional dead time: MOVE_CTRL_COOLDOWN_EN.
//
// state   | meaning
// IDLE    | ready for a command
// READ    | map RAM address presented for the target tile
// RESOLVE | RAM data valid, resolver results registered
// COMMIT  | move_done pulse, optional tile write
// COOL    | post-move dead time (cooldown build only)
module move_ctrl
  import move_ctrl_pkg::*;
#(
  parameter int MAP_W       = MAP_W_DEF,
  parameter int MAP_H       = MAP_H_DEF,
  parameter int INIT_X      = INIT_X_DEF,
  parameter int INIT_Y      = INIT_Y_DEF,
  parameter int INIT_HEALTH = INIT_HEALTH_DEF,
  parameter int HEALTH_MAX  = HEALTH_MAX_DEF
`ifdef MOVE_CTRL_COOLDOWN_EN
  , parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  move_ctrl_if.master  bus
);

  localparam logic [3:0] INIT_X_L      = 4'(INIT_X);
  localparam logic [3:0] INIT_Y_L      = 4'(INIT_Y);
  localparam logic [7:0] INIT_HEALTH_L = 8'(INIT_HEALTH);
  localparam logic [7:0] HEALTH_MAX_L  = 8'(HEALTH_MAX);

  state_e      r_state;
  state_e      w_next;
  logic        w_ready;
  logic        w_done;
  logic        w_done_q;
  logic        w_accept;

  logic [3:0]  r_tgt_x;
  logic [3:0]  r_tgt_y;
  logic [3:0]  r_player_x;
  logic [3:0]  r_player_y;
  logic [3:0]  r_key_num;
  logic [7:0]  r_health;
  logic        r_wr_pending;
  logic        r_blocked;
  logic [7:0]  r_wr_addr;
  logic [15:0] r_wr_data;

  logic [3:0]  w_tgt_x;
  logic [3:0]  w_tgt_y;
  logic        w_off_map;

  move_target #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H)
  ) u_target (
    .i_pos_x   (r_player_x),
    .i_pos_y   (r_player_y),
    .i_dir     (bus.move_dir),
    .o_tgt_x   (w_tgt_x),
    .o_tgt_y   (w_tgt_y),
    .o_off_map (w_off_map)
  );

`ifdef MOVE_CTRL_COOLDOWN_EN
  localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);
  // COMMIT is the first dead cycle, so COOL itself lasts one cycle less.
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  logic [CNT_W-1:0] r_cool_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cool_cnt <= '0;
    end else if (r_state == ST_COMMIT) begin
      r_cool_cnt <= COOL_LOAD;
    end else if ((r_state == ST_COOL) && (r_cool_cnt != '0)) begin
      r_cool_cnt <= r_cool_cnt - CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.move_valid) w_next = w_off_map ? ST_COMMIT : ST_READ;
      end
      ST_READ:    w_next = ST_RESOLVE;
      ST_RESOLVE: w_next = ST_COMMIT;
      ST_COMMIT: begin
        w_done = 1'b1;
`ifdef MOVE_CTRL_COOLDOWN_EN
        w_next = ST_COOL;
`else
        w_next = ST_IDLE;
`endif
      end
`ifdef MOVE_CTRL_COOLDOWN_EN
      ST_COOL: begin
        if (r_cool_cnt <= CNT_W'(1)) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = w_ready && bus.move_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tgt_x      <= INIT_X_L;
      r_tgt_y      <= INIT_Y_L;
      r_player_x   <= INIT_X_L;
      r_player_y   <= INIT_Y_L;
      r_key_num    <= 4'd0;
      r_health     <= INIT_HEALTH_L;
      r_wr_pending <= 1'b0;
      r_blocked    <= 1'b0;
      r_wr_addr    <= 8'd0;
      r_wr_data    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_tgt_x <= w_tgt_x;
        r_tgt_y <= w_tgt_y;
        if (w_off_map) begin
          r_blocked    <= 1'b1;
          r_wr_pending <= 1'b0;
        end
      end
      if (r_state == ST_RESOLVE) begin
        r_player_x   <= bus.res_goto_x;
        r_player_y   <= bus.res_goto_y;
        r_key_num    <= hold_keys(r_key_num, bus.res_key_num_in);
        r_health     <= sat_health(bus.res_health_in, HEALTH_MAX_L);
        r_blocked    <= (bus.res_goto_x == r_player_x) && (bus.res_goto_y == r_player_y);
        r_wr_pending <= (bus.res_new_tile_id != bus.map_rd_data);
        r_wr_addr    <= {r_tgt_y, r_tgt_x};
        r_wr_data    <= bus.res_new_tile_id;
      end
    end
  end

  // Reset asserted during COMMIT must already suppress the pulse and the write in that cycle.
  assign w_done_q = w_done && rst_n;

  assign bus.move_ready   = w_ready;
  assign bus.move_done    = w_done_q;
  assign bus.move_blocked = w_done_q && r_blocked;

  assign bus.map_rd_addr  = {r_tgt_y, r_tgt_x};
  assign bus.map_wr_en    = w_done_q && r_wr_pending;
  assign bus.map_wr_addr  = r_wr_addr;
  assign bus.map_wr_data  = r_wr_data;

  assign bus.res_tile_id  = bus.map_rd_data;
  assign bus.res_pos_x    = r_tgt_x;
  assign bus.res_pos_y    = r_tgt_y;
  assign bus.res_player_x = r_player_x;
  assign bus.res_player_y = r_player_y;
  assign bus.res_key_num  = r_key_num;
  assign bus.res_health   = r_health;

  assign bus.player_x     = r_player_x;
  assign bus.player_y     = r_player_y;
  assign bus.key_num      = r_key_num;
  assign bus.health       = r_health;

endmodule
